// File: rtl/pool_window_gen_pkg.sv
// Shared definitions for the pooling-window front end.
//   DATA_WIDTH : element width carried through the pooling datapath
//   WIN_ELEMS  : elements per 2x2 pooling window
//   WIN_*      : element slot of each window position inside win_data
//   state_e    : window-generator FSM state, also exported on dbg_state
package pool_window_gen_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int WIN_ELEMS  = 4;

  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row line buffer: simple dual-port RAM, one write port and one
// synchronous read port. No reset; contents are only meaningful once the
// even row of the current band has written them.
//   clk     : clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address, sampled every cycle
//   rd_data : registered read data (one cycle after raddr)
module pool_line_buffer #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rd_data_q <= mem_q[raddr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pool_window_gen.sv
// 2x2 stride-2 pooling window generator.
// Takes one channel of a raster-order pixel stream and emits non-overlapping
// 2x2 windows. The even row of each band is packed into a half-row line
// buffer (one entry per column pair); the odd row completes the windows.
// Odd trailing columns and an odd trailing row are accepted and dropped.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle pulse, latches cfg_* when IDLE
//   cfg_width/height  : frame geometry in pixels / rows
//   s_data/valid/ready: pixel input stream
//   win_data/valid/ready : window output, element k at bits k*DATA_WIDTH
//                       ([0]=TL, [1]=TR, [2]=BL, [3]=BR)
//   busy              : frame in progress (RUN, DRAIN, DONE)
//   frame_done        : one-cycle pulse after the last window is taken
//   cfg_err           : sticky, set by a start with a bad geometry
//   dbg_state         : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its data stable until the
// transfer; ready may depend combinationally on the consumer's ready.
module pool_window_gen
  import pool_window_gen_pkg::*;
#(
  parameter int MAX_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(MAX_WIDTH):0]      cfg_width,
  input  logic [15:0]                     cfg_height,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [WIN_ELEMS*DATA_WIDTH-1:0] win_data,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            cfg_err,
  output state_e                          dbg_state
);

  localparam int CW     = $clog2(MAX_WIDTH) + 1;
  localparam int ADDR_W = (MAX_WIDTH > 2) ? $clog2(MAX_WIDTH / 2) : 1;
  localparam int LB_W   = 2 * DATA_WIDTH;
  localparam int WIN_W  = WIN_ELEMS * DATA_WIDTH;

  state_e                state_q, state_d;
  logic [CW-1:0]         cfg_w_q, cfg_w_d;
  logic [15:0]           cfg_h_q, cfg_h_d;
  logic [CW-1:0]         col_q, col_d;
  logic [15:0]           row_q, row_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  win_valid_q, win_valid_d;
  logic [WIN_W-1:0]      win_data_q, win_data_d;

  logic                  lb_we;
  logic [LB_W-1:0]       lb_wdata;
  logic [LB_W-1:0]       lb_rdata;
  logic [ADDR_W-1:0]     lb_addr;
  logic                  cfg_ok;
  logic                  row_live;
  logic                  accept;

  // Both ports use the column-pair index. The read side runs every cycle, so
  // by the time the odd-column pixel arrives (at least one cycle after the
  // even one) the entry for this pair is already on rd_data. Writes happen
  // only on even rows and reads are consumed only on odd rows.
  assign lb_addr = col_q[ADDR_W:1];

  pool_line_buffer #(
    .WIDTH (LB_W),
    .AW    (ADDR_W),
    .DEPTH (1 << ADDR_W)
  ) u_lb (
    .clk     (clk),
    .we      (lb_we),
    .waddr   (lb_addr),
    .wdata   (lb_wdata),
    .raddr   (lb_addr),
    .rd_data (lb_rdata)
  );

  assign cfg_ok = (cfg_width >= CW'(2)) && (cfg_width <= CW'(MAX_WIDTH)) &&
                  (cfg_height >= 16'd2);

  // Rows past the last even boundary belong to no window.
  assign row_live = row_q < {cfg_h_q[15:1], 1'b0};

  always_comb begin
    state_d     = state_q;
    cfg_w_d     = cfg_w_q;
    cfg_h_d     = cfg_h_q;
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    cfg_err_d   = cfg_err_q;
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    s_ready     = 1'b0;
    lb_we       = 1'b0;
    lb_wdata    = {s_data, pair_q};
    accept      = 1'b0;

    // A taken window frees the output register unless reloaded below.
    if (win_valid_q && win_ready) win_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            cfg_w_d   = cfg_width;
            cfg_h_d   = cfg_height;
            col_d     = '0;
            row_d     = '0;
            cfg_err_d = 1'b0;
            state_d   = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        s_ready = !win_valid_q || win_ready;
        accept  = s_valid && s_ready;
        if (accept) begin
          if (!col_q[0]) begin
            pair_d = s_data;
          end else if (row_live) begin
            if (!row_q[0]) begin
              lb_we = 1'b1;
            end else begin
              win_data_d[WIN_TL*DATA_WIDTH +: DATA_WIDTH] = lb_rdata[DATA_WIDTH-1:0];
              win_data_d[WIN_TR*DATA_WIDTH +: DATA_WIDTH] = lb_rdata[LB_W-1:DATA_WIDTH];
              win_data_d[WIN_BL*DATA_WIDTH +: DATA_WIDTH] = pair_q;
              win_data_d[WIN_BR*DATA_WIDTH +: DATA_WIDTH] = s_data;
              win_valid_d = 1'b1;
            end
          end
          // Wrap on the last physical column so an odd trailing pixel is
          // consumed but never paired.
          if (col_q == cfg_w_q - CW'(1)) begin
            col_d = '0;
            row_d = row_q + 16'd1;
            if (row_q == cfg_h_q - 16'd1) state_d = ST_DRAIN;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (!win_valid_q || win_ready) state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_w_q     <= '0;
      cfg_h_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      cfg_err_q   <= 1'b0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cfg_w_q     <= cfg_w_d;
      cfg_h_q     <= cfg_h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      cfg_err_q   <= cfg_err_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign cfg_err    = cfg_err_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pool_window_gen.sv
module tb_pool_window_gen;
  import pool_window_gen_pkg::*;

  localparam int MAXW   = 64;
  localparam int CW     = $clog2(MAXW) + 1;
  localparam int DW     = DATA_WIDTH;
  localparam int BUDGET = 4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start;
  logic [CW-1:0]   cfg_width;
  logic [15:0]     cfg_height;
  logic [DW-1:0]   s_data;
  logic            s_valid, s_ready;
  logic [4*DW-1:0] win_data;
  logic            win_valid, win_ready;
  logic            busy, frame_done, cfg_err;
  state_e          dbg_state;

  pool_window_gen #(.MAX_WIDTH(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0]   pix_q[$];
  logic [4*DW-1:0] exp_q[$];
  logic [4*DW-1:0] got_q[$];
  logic [4*DW-1:0] stall_data_q[$];
  logic            stall_rdy_q[$];
  int              px_acc;
  bit              finished;

  task automatic fill_pixels(input int n, input bit seq);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(seq ? DW'(i) : DW'($urandom));
  endtask

  // Reference model: windows straight from the frame geometry.
  task automatic build_expected(input int w, input int h);
    exp_q.delete();
    for (int r = 0; r + 1 < h; r += 2)
      for (int c = 0; c + 1 < w; c += 2)
        exp_q.push_back({pix_q[(r+1)*w + c + 1], pix_q[(r+1)*w + c],
                         pix_q[r*w + c + 1], pix_q[r*w + c]});
  endtask

  // ---------------- driver ----------------
  // Starts a frame and streams pix_q; collects accepted windows into got_q.
  // stall_n > 0 holds win_ready low for stall_n cycles from the first window.
  // abort_n > 0 returns once that many windows have been taken.
  task automatic drive_frame(input int w, input int h, input int vpct,
                             input int rpct, input int stall_n, input int abort_n);
    bit stall_started = 0;
    int stall_left = 0;
    got_q.delete();
    stall_data_q.delete();
    stall_rdy_q.delete();
    px_acc   = 0;
    finished = 0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      start      = (cyc == 0);
      cfg_width  = CW'(w);
      cfg_height = 16'(h);
      if (stall_n > 0 && (!stall_started || stall_left > 0)) win_ready = 1'b0;
      else win_ready = ($urandom_range(99) < rpct);
      if (px_acc < w * h && $urandom_range(99) < vpct) begin
        s_valid = 1'b1;
        s_data  = pix_q[px_acc];
      end else begin
        s_valid = 1'b0;
        s_data  = DW'($urandom);
      end
      #1;
      if (stall_n > 0 && !win_ready && win_valid) begin
        stall_data_q.push_back(win_data);
        stall_rdy_q.push_back(s_ready);
        if (!stall_started) begin
          stall_started = 1;
          stall_left    = stall_n - 1;
        end else begin
          stall_left--;
        end
      end
      if (s_valid && s_ready) px_acc++;
      if (win_valid && win_ready) got_q.push_back(win_data);
      if (frame_done) begin
        finished = 1;
        break;
      end
      if (abort_n > 0 && got_q.size() >= abort_n) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; win_ready = 1'b0;
    cfg_width = '0; cfg_height = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({s_ready, win_valid, busy, frame_done, cfg_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {s_ready, win_valid, busy, frame_done, cfg_err});
    end
    checks++;
    if (win_data !== '0) begin
      errors++; $display("FAIL reset_win_data: got %0h want 0", win_data);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_4x4();
    fill_pixels(16, 1);
    build_expected(4, 4);
    drive_frame(4, 4, 100, 100, 0, 0);
    checks++;
    if (finished !== 1'b1) begin errors++; $display("FAIL f4x4_done: got %0d want 1", finished); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL f4x4_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL f4x4_win%0d: got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk); s_valid = 1'b0; #1;
    checks++;
    if ({busy, frame_done} !== 2'b00) begin
      errors++; $display("FAIL f4x4_idle_after: got %b want 00", {busy, frame_done});
    end
  endtask

  task automatic test_odd_dims();
    fill_pixels(15, 1);
    build_expected(5, 3);
    drive_frame(5, 3, 100, 100, 0, 0);
    checks++;
    if (finished !== 1'b1) begin errors++; $display("FAIL odd_done: got %0d want 1", finished); end
    checks++;
    if (px_acc !== 15) begin errors++; $display("FAIL odd_accepted: got %0d want 15", px_acc); end
    checks++;
    if (got_q.size() !== 2) begin errors++; $display("FAIL odd_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL odd_win%0d: got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk); s_valid = 1'b0; #1;
  endtask

  task automatic test_stall();
    fill_pixels(8, 1);
    build_expected(4, 2);
    drive_frame(4, 2, 100, 100, 5, 0);
    checks++;
    if (stall_data_q.size() !== 5) begin
      errors++; $display("FAIL stall_cycles: got %0d want 5", stall_data_q.size());
    end
    for (int i = 0; i < stall_data_q.size(); i++) begin
      checks++;
      if (stall_data_q[i] !== exp_q[0] || stall_rdy_q[i] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got data %0h s_ready %b want data %0h s_ready 0",
                 i, stall_data_q[i], stall_rdy_q[i], exp_q[0]);
      end
    end
    checks++;
    if (got_q.size() !== 2) begin errors++; $display("FAIL stall_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_win%0d: got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk); s_valid = 1'b0; #1;
  endtask

  task automatic test_gaps();
    fill_pixels(24, 0);
    build_expected(6, 4);
    drive_frame(6, 4, 50, 100, 0, 0);
    checks++;
    if (finished !== 1'b1 || got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL gaps_count: got done %0d n %0d want done 1 n %0d", finished, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL gaps_win%0d: got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk); s_valid = 1'b0; #1;
  endtask

  task automatic test_cfg_err();
    int bad_w[2] = '{1, MAXW + 2};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cfg_width = CW'(bad_w[k]); cfg_height = 16'd4; start = 1'b1; s_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (cfg_err !== 1'b1 || dbg_state !== ST_IDLE || s_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_w%0d: got err %b state %0d s_ready %b busy %b want err 1 state 0 s_ready 0 busy 0",
                 bad_w[k], cfg_err, dbg_state, s_ready, busy);
      end
    end
    s_valid = 1'b0;
    fill_pixels(4, 0);
    build_expected(2, 2);
    drive_frame(2, 2, 100, 100, 0, 0);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err); end
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL cfg_err_2x2: got n %0d win %0h want n 1 win %0h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
    end
    @(negedge clk); s_valid = 1'b0; #1;
  endtask

  task automatic test_mid_reset();
    fill_pixels(32, 0);
    build_expected(8, 4);
    drive_frame(8, 4, 100, 100, 0, 3);
    checks++;
    if (got_q.size() !== 3) begin errors++; $display("FAIL abort_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_win%0d: got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk); rst = 1'b1; s_valid = 1'b0; win_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({s_ready, win_valid, busy, frame_done, cfg_err} !== 5'b0 || win_data !== '0) begin
      errors++;
      $display("FAIL abort_reset: got flags %b data %0h want 00000 0",
               {s_ready, win_valid, busy, frame_done, cfg_err}, win_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); s_valid = 1'b1; s_data = DW'($urandom); #1;
      checks++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
        errors++; $display("FAIL abort_quiet%0d: got valid %b done %b want 0 0", i, win_valid, frame_done);
      end
    end
    s_valid = 1'b0;
    fill_pixels(16, 0);
    build_expected(4, 4);
    drive_frame(4, 4, 100, 100, 0, 0);
    checks++;
    if (finished !== 1'b1 || got_q.size() !== 4) begin
      errors++; $display("FAIL fresh_count: got done %0d n %0d want done 1 n 4", finished, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fresh_win%0d: got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk); s_valid = 1'b0; #1;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      int w = $urandom_range(16, 2);
      int h = $urandom_range(7, 2);
      fill_pixels(w * h, 0);
      build_expected(w, h);
      drive_frame(w, h, 70, 60, 0, 0);
      checks++;
      if (finished !== 1'b1 || px_acc !== w * h || got_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL b2b%0d_%0dx%0d: got done %0d px %0d n %0d want done 1 px %0d n %0d",
                 f, w, h, finished, px_acc, got_q.size(), w * h, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b%0d_win%0d: got %0h want %0h", f, i, got_q[i], exp_q[i]);
        end
      end
      @(negedge clk); s_valid = 1'b0; #1;
    end
  endtask

  initial begin
    test_reset();
    test_4x4();
    test_odd_dims();
    test_stall();
    test_gaps();
    test_cfg_err();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
